// File: rtl/a0_trace_pkg.sv
// rtl/a0_trace_pkg.sv - shared types and constants for the a0 trace buffer
// Purpose: default trace entry layout and the drop-counter saturation value.
// Ports: none (package).
package a0_trace_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TS_WIDTH   = 32;

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   typedef struct packed {
      logic [DEF_DATA_WIDTH-1:0] data;
      logic [DEF_TS_WIDTH-1:0]   ts;
   } trace_entry_t;

endpackage

// File: rtl/a0_trace_buffer_sync_fifo.sv
// rtl/a0_trace_buffer_sync_fifo.sv - show-ahead single-clock FIFO with flush
// Purpose: stores entries of a parameterised type; head is visible on rdata
//          without a read request.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, wdata   write request and entry; accepted when not full or when a
//                 pop frees a slot on the same edge
//   pop           consume head; ignored when empty
//   clear         synchronous flush, overrides push and pop
//   rdata         head entry, zero when empty
//   count         occupancy, full, empty
module sync_fifo
   import a0_trace_pkg::*;
#(
   parameter type entry_t = trace_entry_t,
   parameter int  DEPTH   = 16,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  entry_t        wdata,
   output entry_t        rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   // a pop on a full FIFO frees the slot the push needs
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage is not reset; rdata is masked by empty instead
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/a0_trace_buffer.sv
// rtl/a0_trace_buffer.sv - timestamped change log of the core a0 register
// Purpose: pushes {a0, ts} into a show-ahead FIFO whenever a0 changes while
//          enabled; never back-pressures the core, counts dropped entries.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   a0, en, clear            observed value, capture enable, flush
//   out_valid/out_ready      head handshake; out_data/out_ts head entry
//   count                    occupancy
//   overflow, drop_count     sticky drop flag, saturating drop counter
module a0_trace_buffer
   import a0_trace_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter int  DEPTH      = 16,
   parameter int  TS_WIDTH   = 32,
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a0,
   input  logic                  en,
   input  logic                  clear,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [TS_WIDTH-1:0]   out_ts,
   output logic [CW-1:0]         count,
   output logic                  overflow,
   output logic [15:0]           drop_count
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [TS_WIDTH-1:0]   ts;
   } entry_t;

   logic [TS_WIDTH-1:0]   ts;
   logic [DATA_WIDTH-1:0] a0_prev;
   logic                  change;
   logic                  pop;
   logic                  drop;
   logic                  full;
   logic                  empty;
   entry_t                wentry;
   entry_t                rentry;

   assign change    = en && (a0 != a0_prev);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // full implies valid, so any ready pop makes room for the new entry
   assign drop      = change && full && !pop && !clear;
   assign wentry    = '{data: a0, ts: ts};
   assign out_data  = rentry.data;
   assign out_ts    = rentry.ts;

   sync_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (change),
      .pop   (pop),
      .clear (clear),
      .wdata (wentry),
      .rdata (rentry),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // ts and a0_prev run independently of en and clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts      <= '0;
         a0_prev <= '0;
      end else begin
         ts      <= ts + 1'b1;
         a0_prev <= a0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: doc/a0_trace_buffer.md
# a0_trace_buffer

Observation block downstream of the pipelined core: it consumes the core's `a0` result register output and records every change of `a0` as a timestamped entry in a show-ahead FIFO. A host-side consumer (display driver or bench) drains the entries over a valid/ready interface. The core is never back-pressured, so lost entries are counted instead.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of `a0` and of stored data
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `TS_WIDTH`, 32, free-running timestamp width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `a0` in DATA_WIDTH: core `a0` value, sampled every edge
- `en` in 1: capture enable
- `clear` in 1: synchronous flush of FIFO and statistics
- `out_valid` out 1: head entry available
- `out_ready` in 1: consumer accepts head
- `out_data` out DATA_WIDTH: head entry `a0` value
- `out_ts` out TS_WIDTH: head entry timestamp
- `count` out $clog2(DEPTH)+1: current occupancy
- `overflow` out 1: sticky, at least one entry dropped
- `drop_count` out 16: dropped entries, saturating

## Operation
- `ts` counter: reset 0, +1 every edge, wraps at 2^TS_WIDTH.
- `a0_prev` register: reset 0, loads `a0` every edge regardless of `en`.
- Change event at an edge: `en && (a0 != a0_prev)`. A nonzero `a0` on the first edge after reset is an event.
- Push entry {a0, ts}. The stored `ts` is the counter value before that edge.
- Pop: `out_valid && out_ready` at an edge.
- Push and pop on the same edge:
  - Both take effect and `count` is unchanged.
  - When full, the pop frees the slot and the push is accepted.
  - When empty, the push is written and the pop has no effect, because `out_valid` was 0.
- Push when full with no pop:
  - The entry is dropped and `overflow` is set.
  - `drop_count` increments and saturates at 16'hFFFF.
- `clear`:
  - Empties the FIFO and zeroes `overflow` and `drop_count`.
  - Has priority over push and pop on that edge. The event is discarded and not counted.
  - Does not affect `ts` or `a0_prev`.
- `out_data`/`out_ts` are the head entry when `out_valid` is 1, and zero when the FIFO is empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is derived from `count`.

## Timing
- Reset (asynchronous assert, any time including mid-operation) forces immediately:
  - `out_valid`=0, `count`=0, `overflow`=0, `drop_count`=0, `out_data`=0, `out_ts`=0
  - `ts`=0, `a0_prev`=0
  - All pending entries are lost.
- Latency: an event captured at edge k gives `out_valid`=1 after edge k, provided the FIFO was empty and not cleared.
- `out_valid` depends only on state, never combinationally on `out_ready`.
- `out_data`/`out_ts` change only at edges.
- A head entry stays stable while `out_valid && !out_ready`.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Package `a0_trace_pkg` contains:
  - Struct `trace_entry_t` {data, ts}, parameterised by the defaults above.
  - Constant `DROP_MAX` = 16'hFFFF.
- Sub-module `sync_fifo`:
  - Show-ahead, single clock, async active-low reset.
  - Parameterised entry type and depth.
  - Ports: push, pop, wdata, rdata, count, full, empty, clear.
- The top level holds `ts`, `a0_prev`, event detection, and the overflow/drop logic.

## Test plan
- Reset release with `a0`=5 and `en`=1, `out_ready`=0:
  - After the first edge, `out_valid`=1, `out_data`=5, `out_ts`=0, `count`=1.
- `a0` held at 7 for 10 edges, then 9, with `en`=1:
  - Exactly two entries: {7, t0} and {9, t0+10}.
  - An unchanged `a0` produces no push.
- `out_ready`=0 with DEPTH+3 changes:
  - `count`=DEPTH, `overflow`=1, `drop_count`=3.
  - Entries drain in order, oldest first.
- FIFO full, with a push and `out_ready`=1 on the same edge:
  - `count` stays DEPTH, no drop.
  - The new entry appears as last.
- `clear` asserted on the same edge as a change:
  - `count`=0, `overflow`=0, `drop_count`=0, `out_valid`=0.
  - `ts` keeps counting.
  - The next change is captured normally.
- `rst` asserted mid-stream with 4 entries queued:
  - All outputs go to zero without waiting for a clock edge.
  - After release, `ts` restarts at 0.
